// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding, word geometry
// and the word-count range check.
package program_loader_pkg;

  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam int unsigned BYTE_CNT_W      = 2;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRecv  = 3'd1,
    StWrite = 3'd2,
    StRun   = 3'd3,
    StErr   = 3'd4
  } state_e;

  // A load must write at least one word and must fit in instruction memory.
  function automatic logic count_ok(input int unsigned count, input int unsigned depth);
    return (count != 0) && (count <= depth);
  endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs a byte stream little-endian into 32-bit words; byte lane 0 lands in bits 7:0.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               load,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               last_byte
);

  logic [BYTE_CNT_W-1:0] r_byte_cnt;
  logic [INSTR_W-1:0]    r_word;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (load) begin
      for (int unsigned i = 0; i < BYTES_PER_INSTR; i++) begin
        if (r_byte_cnt == BYTE_CNT_W'(i)) begin
          r_word[8*i +: 8] <= byte_in;
        end
      end
      // Two-bit counter wraps to lane 0 after the fourth byte.
      r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  assign word      = r_word;
  assign last_byte = (r_byte_cnt == BYTE_CNT_W'(BYTES_PER_INSTR - 1));

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a program byte stream, writes it word by word into instruction
// memory from address 0, and holds the core in reset until the image is complete.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned CNT_W      = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   word_count,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [63:0]        imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               error
);

  state_e             r_state;
  state_e             w_state_next;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_word_idx;
  logic               r_done;

  logic               w_count_ok;
  logic               w_start_accept;
  logic               w_load;
  logic               w_last_byte;
  logic               w_last_word;
  logic [INSTR_W-1:0] w_word;

  assign w_count_ok  = count_ok(32'(word_count), IMEM_WORDS);
  assign w_last_word = (r_word_idx == r_count - 1'b1);
  assign w_load      = (r_state == StRecv) && in_valid;

  // start is only honoured outside an active load.
  assign w_start_accept = start && w_count_ok &&
                          ((r_state == StIdle) || (r_state == StRun) || (r_state == StErr));

  word_assembler u_word_assembler (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_start_accept),
    .load      (w_load),
    .byte_in   (in_data),
    .word      (w_word),
    .last_byte (w_last_byte)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StRun, StErr: begin
        if (start) begin
          w_state_next = w_count_ok ? StRecv : StErr;
        end
      end
      StRecv: begin
        if (in_valid && w_last_byte) begin
          w_state_next = StWrite;
        end
      end
      StWrite: begin
        w_state_next = w_last_word ? StRun : StRecv;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_count    <= '0;
      r_word_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // done marks only the first RUN cycle after the final write.
      r_done  <= (r_state == StWrite) && w_last_word;
      if (w_start_accept) begin
        r_count    <= word_count;
        r_word_idx <= '0;
      end else if ((r_state == StWrite) && !w_last_word) begin
        r_word_idx <= r_word_idx + 1'b1;
      end
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    imem_addr  = '0;
    imem_wdata = '0;
    cpu_reset  = 1'b1;
    busy       = 1'b0;
    error      = 1'b0;
    unique case (r_state)
      StRecv: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      StWrite: begin
        imem_we    = 1'b1;
        busy       = 1'b1;
        imem_addr  = {{(62 - CNT_W){1'b0}}, r_word_idx, 2'b00};
        imem_wdata = w_word;
      end
      StRun: begin
        cpu_reset = 1'b0;
      end
      StErr: begin
        error = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign done = r_done;

endmodule
